// File: rtl/noc_inject_queue.sv
// noc_inject_queue: per-VC injection FIFOs between a NoC client and its router's
// local port, round-robin arbitration with grant lock on stall. INJ_STATS_EN adds counters.
module noc_inject_queue #(
  parameter int VC_W  = 3,
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter int D_W   = 512,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 c_v,
  input  logic [VC_W-1:0]      c_vc,
  input  logic [X_W-1:0]       c_x,
  input  logic [Y_W-1:0]       c_y,
  input  logic [D_W-1:0]       c_data,
  output logic                 c_ack,
  output logic                 r_v,
  output logic [VC_W-1:0]      r_vc,
  output logic [X_W-1:0]       r_x,
  output logic [Y_W-1:0]       r_y,
  output logic [D_W-1:0]       r_data,
  input  logic                 r_ready,
  output logic [(1<<VC_W)-1:0] vc_full,
  output logic [31:0]          accepted_cnt,
  output logic [31:0]          stall_cnt
);
  localparam int N_VC  = 1 << VC_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int E_W   = X_W + Y_W + D_W;

  logic [E_W-1:0]   mem_q    [N_VC][DEPTH];
  logic [E_W-1:0]   mem_d    [N_VC][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [N_VC];
  logic [PTR_W-1:0] wr_ptr_d [N_VC];
  logic [PTR_W-1:0] rd_ptr_q [N_VC];
  logic [PTR_W-1:0] rd_ptr_d [N_VC];
  logic [OCC_W-1:0] occ_q    [N_VC];
  logic [OCC_W-1:0] occ_d    [N_VC];
  logic [N_VC-1:0]  full_q, full_d;
  logic [VC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [VC_W-1:0]  grant_q, grant_d;
  logic             lock_q, lock_d;

  logic [N_VC-1:0]  req;
  logic [VC_W-1:0]  grant;
  logic [VC_W-1:0]  cand;
  logic             found;
  logic             push, pop;
  logic [E_W-1:0]   head;

  // Full comes from registered state only, so a same-cycle pop never opens c_ack.
  assign c_ack   = c_v && !full_q[c_vc] && !rst;
  assign push    = c_ack;
  assign pop     = r_v && r_ready;
  assign vc_full = full_q;

  always_comb begin
    req   = '0;
    grant = rr_ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N_VC; i++) begin
      req[i] = (occ_q[i] != '0);
    end
    for (int i = 0; i < N_VC; i++) begin
      cand = rr_ptr_q + VC_W'(i);
      if (!found && req[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
    if (lock_q) begin
      grant = grant_q;
    end
  end

  always_comb begin
    r_v  = (|req) && !rst;
    head = mem_q[grant][rd_ptr_q[grant]];
    r_vc = '0;
    {r_x, r_y, r_data} = '0;
    if (r_v) begin
      r_vc = grant;
      {r_x, r_y, r_data} = head;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    full_d   = full_q;
    if (push) begin
      mem_d[c_vc][wr_ptr_q[c_vc]] = {c_x, c_y, c_data};
      wr_ptr_d[c_vc] = wr_ptr_q[c_vc] + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d[grant] = rd_ptr_q[grant] + PTR_W'(1);
    end
    for (int i = 0; i < N_VC; i++) begin
      occ_d[i] = occ_q[i] + OCC_W'(push && (c_vc == VC_W'(i)))
                          - OCC_W'(pop && (grant == VC_W'(i)));
      full_d[i] = (occ_d[i] == OCC_W'(DEPTH));
    end
  end

  // A stalled offer freezes the grant until the router takes it.
  always_comb begin
    lock_d   = lock_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (pop) begin
      lock_d   = 1'b0;
      rr_ptr_d = grant + VC_W'(1);
    end else if (r_v) begin
      lock_d  = 1'b1;
      grant_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_VC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        occ_q[i]    <= '0;
      end
      full_q   <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      lock_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      lock_q   <= lock_d;
    end
  end

`ifdef INJ_STATS_EN
  logic [31:0] accepted_cnt_q, accepted_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    accepted_cnt_d = accepted_cnt_q + 32'(c_ack);
    stall_cnt_d    = stall_cnt_q + 32'(r_v && !r_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accepted_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      accepted_cnt_q <= accepted_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign accepted_cnt = accepted_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`else
  assign accepted_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_noc_inject_queue.sv
// Bench for noc_inject_queue: directed scenarios plus randomized traffic, all checked
// against a queue-level model of per-VC FIFOs and round-robin/lock arbitration.
module tb_noc_inject_queue;
  localparam int VC_W  = 3;
  localparam int X_W   = 2;
  localparam int Y_W   = 2;
  localparam int D_W   = 512;
  localparam int DEPTH = 4;
  localparam int N_VC  = 8;
  localparam int E_W   = X_W + Y_W + D_W;

  logic            clk = 1'b0;
  logic            rst;
  logic            c_v;
  logic [VC_W-1:0] c_vc;
  logic [X_W-1:0]  c_x;
  logic [Y_W-1:0]  c_y;
  logic [D_W-1:0]  c_data;
  logic            c_ack;
  logic            r_v;
  logic [VC_W-1:0] r_vc;
  logic [X_W-1:0]  r_x;
  logic [Y_W-1:0]  r_y;
  logic [D_W-1:0]  r_data;
  logic            r_ready;
  logic [N_VC-1:0] vc_full;
  logic [31:0]     accepted_cnt;
  logic [31:0]     stall_cnt;

  int checks = 0;
  int errors = 0;

  // Model: each VC is a list with head at index 0, plus rr pointer and lock.
  logic [E_W-1:0] m_ent [N_VC][DEPTH];
  int             m_cnt [N_VC];
  int             m_rr;
  bit             m_lock;
  int             m_lvc;
  int unsigned    m_acc;
  int unsigned    m_stall;

  noc_inject_queue #(.VC_W(VC_W), .X_W(X_W), .Y_W(Y_W), .D_W(D_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .c_v(c_v), .c_vc(c_vc), .c_x(c_x), .c_y(c_y), .c_data(c_data),
    .c_ack(c_ack), .r_v(r_v), .r_vc(r_vc), .r_x(r_x), .r_y(r_y), .r_data(r_data),
    .r_ready(r_ready), .vc_full(vc_full), .accepted_cnt(accepted_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [D_W-1:0] rand_data();
    logic [D_W-1:0] r;
    for (int i = 0; i < D_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int m_grant();
    if (m_lock) return m_lvc;
    for (int i = 0; i < N_VC; i++) begin
      if (m_cnt[(m_rr + i) % N_VC] > 0) return (m_rr + i) % N_VC;
    end
    return -1;
  endfunction

  function automatic bit m_ack();
    return c_v && (m_cnt[c_vc] != DEPTH) && !rst;
  endfunction

  function automatic logic [N_VC-1:0] m_full();
    logic [N_VC-1:0] f;
    for (int i = 0; i < N_VC; i++) f[i] = (m_cnt[i] == DEPTH);
    return f;
  endfunction

  task automatic model_step();
    bit ack, rv;
    int g;
    if (rst) begin
      for (int i = 0; i < N_VC; i++) m_cnt[i] = 0;
      m_rr = 0; m_lock = 0; m_lvc = 0; m_acc = 0; m_stall = 0;
      return;
    end
    ack = m_ack();
    g   = m_grant();
    rv  = (g >= 0);
    if (ack) m_acc++;
    if (rv && !r_ready) m_stall++;
    if (rv && r_ready) begin
      for (int k = 0; k < DEPTH - 1; k++) m_ent[g][k] = m_ent[g][k+1];
      m_cnt[g]--;
      m_rr   = (g + 1) % N_VC;
      m_lock = 0;
    end else if (rv) begin
      m_lock = 1;
      m_lvc  = g;
    end
    if (ack) begin
      m_ent[c_vc][m_cnt[c_vc]] = {c_x, c_y, c_data};
      m_cnt[c_vc]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_pkt(input int vc, input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                           input logic [D_W-1:0] d);
    c_v = 1'b1; c_vc = VC_W'(vc); c_x = x; c_y = y; c_data = d;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; c_v = 1'b1; c_vc = 3'd3; r_ready = 1'b1;
    #1;
    checks++;
    if (c_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_c_ack: got %b expected 0", c_ack); end
    checks++;
    if (r_v !== 1'b0) begin errors++; $display("[TB] FAIL reset_r_v: got %b expected 0", r_v); end
    tick();
    tick();
    rst = 1'b0; c_v = 1'b0;
    #1;
    checks++;
    if (r_v !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_r_v: got %b expected 0", r_v); end
    checks++;
    if (vc_full !== 8'h00) begin errors++; $display("[TB] FAIL post_reset_vc_full: got %h expected 00", vc_full); end
    checks++;
    if ({r_vc, r_x, r_y, r_data} !== '0) begin errors++; $display("[TB] FAIL post_reset_r_fields: got nonzero expected 0"); end
    checks++;
    if (accepted_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL post_reset_counters: got %0d/%0d expected 0/0", accepted_cnt, stall_cnt);
    end
  endtask

  task automatic test_basic();
    r_ready = 1'b1;
    drive_pkt(2, 2'd1, 2'd3, 512'hAB);
    #1;
    checks++;
    if (c_ack !== 1'b1) begin errors++; $display("[TB] FAIL basic_c_ack: got %b expected 1", c_ack); end
    checks++;
    if (r_v !== 1'b0) begin errors++; $display("[TB] FAIL basic_no_bypass: got r_v %b expected 0", r_v); end
    tick();
    c_v = 1'b0;
    #1;
    checks++;
    if (r_v !== 1'b1 || r_vc !== 3'd2 || r_x !== 2'd1 || r_y !== 2'd3 || r_data !== 512'hAB) begin
      errors++;
      $display("[TB] FAIL basic_present: got v=%b vc=%0d x=%0d y=%0d data=%h expected v=1 vc=2 x=1 y=3 data=ab",
               r_v, r_vc, r_x, r_y, r_data[31:0]);
    end
    tick();
    #1;
    checks++;
    if (r_v !== 1'b0) begin errors++; $display("[TB] FAIL basic_drained: got r_v %b expected 0", r_v); end
  endtask

  task automatic test_full();
    logic [D_W-1:0] first_d;
    r_ready = 1'b0;
    first_d = rand_data();
    for (int k = 0; k < DEPTH; k++) begin
      drive_pkt(0, 2'(k), 2'(3 - k), (k == 0) ? first_d : rand_data());
      #1;
      checks++;
      if (c_ack !== 1'b1) begin errors++; $display("[TB] FAIL full_push_ack_%0d: got %b expected 1", k, c_ack); end
      tick();
    end
    drive_pkt(0, 2'd2, 2'd2, rand_data());
    #1;
    checks++;
    if (vc_full[0] !== 1'b1) begin errors++; $display("[TB] FAIL full_flag_set: got %b expected 1", vc_full[0]); end
    checks++;
    if (c_ack !== 1'b0) begin errors++; $display("[TB] FAIL full_5th_ack: got %b expected 0", c_ack); end
    tick();
    r_ready = 1'b1;
    #1;
    checks++;
    if (c_ack !== 1'b0) begin errors++; $display("[TB] FAIL full_no_comb_ready_path: got %b expected 0", c_ack); end
    checks++;
    if (r_v !== 1'b1 || r_vc !== 3'd0 || r_data !== first_d) begin
      errors++; $display("[TB] FAIL full_head: got v=%b vc=%0d expected v=1 vc=0 with first payload", r_v, r_vc);
    end
    tick();
    r_ready = 1'b0;
    #1;
    checks++;
    if (vc_full[0] !== 1'b0) begin errors++; $display("[TB] FAIL full_flag_clear: got %b expected 0", vc_full[0]); end
    checks++;
    if (c_ack !== 1'b1) begin errors++; $display("[TB] FAIL full_5th_accept: got %b expected 1", c_ack); end
    tick();
    c_v = 1'b0;
  endtask

  task automatic test_drain();
    int g;
    c_v = 1'b0; r_ready = 1'b1;
    for (int k = 0; k < 4 * N_VC * DEPTH; k++) begin
      #1;
      g = m_grant();
      if (g < 0) break;
      checks++;
      if (r_v !== 1'b1 || r_vc !== VC_W'(g) || {r_x, r_y, r_data} !== m_ent[g][0]) begin
        errors++; $display("[TB] FAIL drain_pkt: got v=%b vc=%0d expected v=1 vc=%0d", r_v, r_vc, g);
      end
      tick();
    end
    #1;
    checks++;
    if (r_v !== 1'b0 || vc_full !== 8'h00) begin
      errors++; $display("[TB] FAIL drain_empty: got v=%b full=%h expected v=0 full=00", r_v, vc_full);
    end
  endtask

  task automatic test_rr();
    int order [3];
    order = '{1, 3, 5};
    rst = 1'b1; c_v = 1'b0; r_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_pkt(order[k], 2'(k), 2'(k), rand_data());
      tick();
    end
    c_v = 1'b0; r_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (r_v !== 1'b1 || r_vc !== VC_W'(order[k])) begin
        errors++; $display("[TB] FAIL rr_order_%0d: got v=%b vc=%0d expected v=1 vc=%0d", k, r_v, r_vc, order[k]);
      end
      tick();
    end
    r_ready = 1'b0;
    drive_pkt(1, 2'd0, 2'd1, rand_data());
    tick();
    drive_pkt(3, 2'd1, 2'd0, rand_data());
    tick();
    c_v = 1'b0; r_ready = 1'b1;
    #1;
    checks++;
    if (r_vc !== 3'd1) begin errors++; $display("[TB] FAIL rr_wrap_first: got vc=%0d expected 1", r_vc); end
    tick();
    #1;
    checks++;
    if (r_vc !== 3'd3 || r_v !== 1'b1) begin errors++; $display("[TB] FAIL rr_wrap_second: got vc=%0d expected 3", r_vc); end
    tick();
  endtask

  task automatic test_lock();
    logic [D_W-1:0] d4, d0;
    d4 = rand_data(); d0 = rand_data();
    r_ready = 1'b0;
    drive_pkt(4, 2'd2, 2'd1, d4);
    tick();
    c_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (r_v !== 1'b1 || r_vc !== 3'd4 || {r_x, r_y, r_data} !== {2'd2, 2'd1, d4}) begin
        errors++; $display("[TB] FAIL lock_hold_%0d: got v=%b vc=%0d expected v=1 vc=4 stable payload", k, r_v, r_vc);
      end
      tick();
    end
    drive_pkt(0, 2'd3, 2'd3, d0);
    tick();
    c_v = 1'b0;
    #1;
    checks++;
    if (r_vc !== 3'd4 || r_data !== d4) begin errors++; $display("[TB] FAIL lock_after_vc0: got vc=%0d expected 4", r_vc); end
    r_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (r_v !== 1'b1 || r_vc !== 3'd0 || r_data !== d0) begin
      errors++; $display("[TB] FAIL lock_next_grant: got v=%b vc=%0d expected v=1 vc=0", r_v, r_vc);
    end
    tick();
  endtask

  task automatic test_reset_flush();
    r_ready = 1'b0;
    drive_pkt(2, 2'd0, 2'd0, rand_data()); tick();
    drive_pkt(2, 2'd1, 2'd0, rand_data()); tick();
    drive_pkt(6, 2'd2, 2'd0, rand_data()); tick();
    drive_pkt(6, 2'd3, 2'd0, rand_data()); tick();
    rst = 1'b1;
    drive_pkt(3, 2'd1, 2'd1, rand_data());
    #1;
    checks++;
    if (c_ack !== 1'b0 || r_v !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_rst_cycle: got ack=%b v=%b expected 0/0", c_ack, r_v);
    end
    tick();
    rst = 1'b0; c_v = 1'b0;
    #1;
    checks++;
    if (r_v !== 1'b0 || vc_full !== 8'h00) begin
      errors++; $display("[TB] FAIL flush_after: got v=%b full=%h expected v=0 full=00", r_v, vc_full);
    end
    drive_pkt(6, 2'd1, 2'd2, rand_data()); tick();
    drive_pkt(2, 2'd2, 2'd1, rand_data()); tick();
    c_v = 1'b0;
    #1;
    checks++;
    if (r_vc !== 3'd6) begin errors++; $display("[TB] FAIL flush_regrant: got vc=%0d expected 6", r_vc); end
  endtask

  task automatic test_stats();
    int exp_acc, exp_stall;
`ifdef INJ_STATS_EN
    exp_acc = 10; exp_stall = 7;
`else
    exp_acc = 0; exp_stall = 0;
`endif
    rst = 1'b1; c_v = 1'b0;
    tick();
    rst = 1'b0; r_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_pkt(k % N_VC, 2'(k), 2'(k + 1), rand_data());
      tick();
    end
    c_v = 1'b0; r_ready = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    #1;
    checks++;
    if (accepted_cnt !== 32'(exp_acc)) begin
      errors++; $display("[TB] FAIL stats_accepted: got %0d expected %0d", accepted_cnt, exp_acc);
    end
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin
      errors++; $display("[TB] FAIL stats_stall: got %0d expected %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_random();
    int g;
    bit erv;
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 149) == 0);
      c_v     = ($urandom_range(0, 9) < 7);
      c_vc    = VC_W'($urandom);
      c_x     = X_W'($urandom);
      c_y     = Y_W'($urandom);
      c_data  = rand_data();
      r_ready = ($urandom_range(0, 9) < 4);
      #1;
      g   = m_grant();
      erv = !rst && (g >= 0);
      checks++;
      if (c_ack !== m_ack()) begin errors++; $display("[TB] FAIL rand_c_ack @%0d: got %b expected %b", n, c_ack, m_ack()); end
      checks++;
      if (vc_full !== m_full()) begin errors++; $display("[TB] FAIL rand_vc_full @%0d: got %h expected %h", n, vc_full, m_full()); end
      checks++;
      if (r_v !== erv) begin errors++; $display("[TB] FAIL rand_r_v @%0d: got %b expected %b", n, r_v, erv); end
      checks++;
      if (erv) begin
        if (r_vc !== VC_W'(g) || {r_x, r_y, r_data} !== m_ent[g][0]) begin
          errors++; $display("[TB] FAIL rand_payload @%0d: got vc=%0d data=%h expected vc=%0d data=%h",
                             n, r_vc, r_data[63:0], g, m_ent[g][0][63:0]);
        end
      end else if ({r_vc, r_x, r_y, r_data} !== '0) begin
        errors++; $display("[TB] FAIL rand_idle_zero @%0d: got vc=%0d expected all-zero outputs", n, r_vc);
      end
      tick();
    end
    rst = 1'b0;
    #1;
    checks++;
`ifdef INJ_STATS_EN
    if (accepted_cnt !== m_acc || stall_cnt !== m_stall) begin
      errors++; $display("[TB] FAIL rand_stats: got %0d/%0d expected %0d/%0d", accepted_cnt, stall_cnt, m_acc, m_stall);
    end
`else
    if (accepted_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL rand_stats: got %0d/%0d expected 0/0", accepted_cnt, stall_cnt);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; c_v = 1'b0; c_vc = '0; c_x = '0; c_y = '0; c_data = '0; r_ready = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_drain();
    test_rr();
    test_lock();
    test_drain();
    test_reset_flush();
    test_drain();
    test_stats();
    test_drain();
    test_random();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_inject_queue.md
Name: noc_inject_queue

Overview:
- Injection buffer between a traffic client and its router's local input port in the torus NoC.
- Accepts client packets on the client valid/ack interface and stores them in per-VC FIFOs.
- Forwards packets to the router on a valid/ready link, using round-robin arbitration across non-empty VCs.
- Decouples client issue timing from router backpressure.

Parameters:
VC_W, 3, VC index width; N_VC = 1<<VC_W queues
X_W, 2, destination x width
Y_W, 2, destination y width
D_W, 512, payload width
DEPTH, 4, entries per VC FIFO, power of 2, >=2

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
c_v  in  1  client packet valid, held until acked
c_vc  in  VC_W  client packet VC
c_x  in  X_W  destination x
c_y  in  Y_W  destination y
c_data  in  D_W  payload
c_ack  out  1  accept pulse to client
r_v  out  1  packet valid to router
r_vc  out  VC_W  VC of presented packet
r_x  out  X_W  destination x
r_y  out  Y_W  destination y
r_data  out  D_W  payload
r_ready  in  1  router accepts this cycle
vc_full  out  N_VC  per-VC full flags
accepted_cnt  out  32  packets accepted (feature only)
stall_cnt  out  32  cycles r_v&&!r_ready (feature only)

Behaviour:
- Reset: all FIFOs empty, pointers and counts 0, rr_ptr=0, lock=0. c_ack=0, r_v=0, vc_full=0, counters 0. r_vc/r_x/r_y/r_data=0 while r_v=0.
- Reset asserted mid-operation flushes all queued packets; no r_v and no c_ack in the reset cycle.
- Enqueue:
  - c_ack = c_v && !full[c_vc] && !rst, combinational.
  - On a clk edge with c_ack=1, {c_x,c_y,c_data} is written to the c_vc FIFO.
  - One accept per cycle at most; the client may present a new packet in the cycle after ack.
- Full: a FIFO holding DEPTH entries deasserts c_ack for that VC.
  - A pop from the same VC in the same cycle does not enable the push; c_ack has no combinational path from r_ready.
  - The full flag clears the cycle after the pop.
- Latency: an empty queue pushed at edge N presents r_v=1 at earliest in cycle N+1. No bypass path.
- Dequeue and arbitration:
  - Request vector req[i] = FIFO i non-empty.
  - If lock=0, grant the first req at or after rr_ptr, scanning ascending and wrapping from N_VC-1 to 0.
  - r_v = |req. r_vc = granted index; r_x/r_y/r_data = head of that FIFO.
- Stability:
  - When r_v=1 and r_ready=0, set lock=1 and hold the granted VC. Payload and r_vc stay stable until the handshake.
  - A higher-priority VC becoming non-empty does not change the grant.
- Handshake: on r_v&&r_ready, pop the granted FIFO, set rr_ptr = grant+1 mod N_VC, clear lock.
- Simultaneous push and pop on the same non-full VC: both take effect; occupancy is unchanged.
- Occupancy counter is clog2(DEPTH)+1 bits wide. Read and write pointers wrap modulo DEPTH.
- vc_full[i] is registered state, equal to occupancy==DEPTH.

Optional Feature:
- Macro: INJ_STATS_EN.
- Defined:
  - accepted_cnt increments on each c_ack.
  - stall_cnt increments each cycle with r_v&&!r_ready.
  - Both are 32-bit, wrap at 2^32, and clear on rst.
- Undefined: accepted_cnt and stall_cnt are tied to 0 and no counter flops exist.

Test Plan:
1. Reset, then c_v=1, c_vc=2, c_x=1, c_y=3, c_data=0xAB with r_ready=1 -> c_ack=1 in the same cycle. Next cycle r_v=1, r_vc=2, r_x=1, r_y=3, r_data=0xAB; one cycle later r_v=0.
2. r_ready=0, push 4 packets on VC 0 -> vc_full[0]=1 after the 4th. A 5th c_v on VC 0 gets c_ack=0 and is held. Pulse r_ready for 1 cycle -> c_ack=1 for the 5th the following cycle.
3. Fill VCs 1, 3, 5 with one packet each, r_ready=1 -> grant order 1, 3, 5. Refill VC 1 and VC 3 -> next grant is 1 (after wrap), then 3.
4. VC 4 presented with r_ready=0 for 3 cycles, then push VC 0 -> r_vc stays 4 with stable payload until r_ready=1. Next grant is 0.
5. Assert rst while VCs 2 and 6 hold 2 packets each -> r_v=0 the next cycle, vc_full=0, rr_ptr restarts at 0.
6. INJ_STATS_EN defined: 10 accepts and 7 stall cycles -> accepted_cnt=10, stall_cnt=7. Undefined: both read 0.
